// File: rtl/oka_pkg.sv
// rtl/oka_pkg.sv - shared state type, width helper and default field polynomial for the OKA multiplier
package oka_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL_E,
    MUL_O,
    MUL_M,
    RED,
    DONE
  } oka_state_t;

  function automatic int half_w(input int n);
    return (n + 1) / 2;
  endfunction

  // x^163 + x^7 + x^6 + x^3 + 1
  localparam logic [163:0] POLY_163 = 164'h8_0000_0000_0000_0000_0000_0000_0000_0000_0000_00C9;

endpackage

// File: rtl/gf2_clmul.sv
// rtl/gf2_clmul.sv - combinational MxM carry-less schoolbook multiplier over GF(2)[x]
module gf2_clmul #(
  parameter int M = 82
) (
  input  logic [M-1:0]   i_a,
  input  logic [M-1:0]   i_b,
  output logic [2*M-2:0] o_y
);

  logic [2*M-2:0] w_a_ext;

  always_comb begin
    w_a_ext = '0;
    w_a_ext[M-1:0] = i_a;
    o_y = '0;
    for (int i = 0; i < M; i++) begin
      if (i_b[i]) begin
        o_y = o_y ^ (w_a_ext << i);
      end
    end
  end

endmodule

// File: rtl/oka_iter_mult.sv
// rtl/oka_iter_mult.sv - iterative overlap-free Karatsuba GF(2)[x] multiplier, one shared MxM core over three cycles
// Optional modular reduction by POLY when OKA_REDUCE_EN is defined.
module oka_iter_mult
  import oka_pkg::*;
#(
  parameter int         N    = 163,
  parameter logic [N:0] POLY = (N+1)'(POLY_163)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  output logic [2*N-2:0] o_y,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic           o_busy
);

  localparam int M  = half_w(N);
  localparam int W  = 2 * N - 1;
  localparam int PW = 2 * M - 1;

  oka_state_t     r_state;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [PW-1:0]  r_p1;
  logic [PW-1:0]  r_p2;
  logic [W-1:0]   r_y;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_busy;

  logic [2*M-1:0] w_a_pad;
  logic [2*M-1:0] w_b_pad;
  logic [M-1:0]   w_ae;
  logic [M-1:0]   w_ao;
  logic [M-1:0]   w_be;
  logic [M-1:0]   w_bo;
  logic [M-1:0]   w_op_a;
  logic [M-1:0]   w_op_b;
  logic [PW-1:0]  w_prod;
  logic [2*M-1:0] w_p1x;
  logic [2*M-1:0] w_p2x;
  logic [2*M-1:0] w_p2s;
  logic [2*M-1:0] w_p3x;
  logic [W-1:0]   w_comb;

  // Padding to 2M bits makes the missing top odd coefficient read as zero for odd N.
  assign w_a_pad = (2*M)'(r_a);
  assign w_b_pad = (2*M)'(r_b);

  always_comb begin
    w_ae = '0;
    w_ao = '0;
    w_be = '0;
    w_bo = '0;
    for (int i = 0; i < M; i++) begin
      w_ae[i] = w_a_pad[2*i];
      w_ao[i] = w_a_pad[2*i+1];
      w_be[i] = w_b_pad[2*i];
      w_bo[i] = w_b_pad[2*i+1];
    end
  end

  always_comb begin
    w_op_a = w_ae ^ w_ao;
    w_op_b = w_be ^ w_bo;
    case (r_state)
      MUL_E: begin
        w_op_a = w_ae;
        w_op_b = w_be;
      end
      MUL_O: begin
        w_op_a = w_ao;
        w_op_b = w_bo;
      end
      default: ;
    endcase
  end

  gf2_clmul #(.M(M)) u_core (
    .i_a (w_op_a),
    .i_b (w_op_b),
    .o_y (w_prod)
  );

  // In MUL_M the core output is P3; even bits take P1 and shifted P2, odd bits take P1^P2^P3.
  assign w_p1x = (2*M)'(r_p1);
  assign w_p2x = (2*M)'(r_p2);
  assign w_p2s = w_p2x << 1;
  assign w_p3x = (2*M)'(w_prod);

  always_comb begin
    w_comb = '0;
    for (int k = 0; k < W; k++) begin
      if (k % 2 == 0) begin
        w_comb[k] = w_p1x[k/2] ^ w_p2s[k/2];
      end else begin
        w_comb[k] = w_p1x[k/2] ^ w_p2x[k/2] ^ w_p3x[k/2];
      end
    end
  end

`ifdef OKA_REDUCE_EN
  function automatic logic [W-1:0] reduce_mod(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int d = W - 1; d >= N; d--) begin
      if (r[d]) begin
        r = r ^ (W'(POLY) << (d - N));
      end
    end
    return r;
  endfunction
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_p1        <= '0;
      r_p2        <= '0;
      r_y         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_a        <= i_a;
            r_b        <= i_b;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= MUL_E;
          end
        end
        MUL_E: begin
          r_p1    <= w_prod;
          r_state <= MUL_O;
        end
        MUL_O: begin
          r_p2    <= w_prod;
          r_state <= MUL_M;
        end
        MUL_M: begin
          r_y <= w_comb;
`ifdef OKA_REDUCE_EN
          r_state <= RED;
`else
          r_out_valid <= 1'b1;
          r_state     <= DONE;
`endif
        end
`ifdef OKA_REDUCE_EN
        RED: begin
          r_y         <= reduce_mod(r_y);
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
`endif
        DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_y         = r_y;

endmodule
